// File: rtl/count_pwm_gen.sv
// PWM generator driven by an external free-running counter.
// Duty updates go through a shadow register and take effect only at a period start.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset; pwm_out held inactive until the first period start
// RUN   | generating PWM from the count bus; left only through reset
module count_pwm_gen #(
  parameter int                WIDTH      = 8,
  parameter bit                INVERT     = 1'b0,
  parameter logic [WIDTH-1:0]  RESET_DUTY = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_load,
  output logic             pwm_out,
  output logic             period_start,
  output logic [WIDTH-1:0] duty_active,
  output logic             load_pending
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_count_q, prev_count_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             pend_q, pend_d;
  logic             pwm_q, pwm_d;
  logic             ps_q, ps_d;
  logic             ps;
  logic [WIDTH-1:0] eff;

  // A counter stalled at zero must not re-trigger, except to leave IDLE.
  assign ps = (count == '0) && ((prev_count_q != '0) || (state_q == S_IDLE));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ps) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    eff          = duty_q;
    duty_d       = duty_q;
    shadow_d     = shadow_q;
    pend_d       = pend_q;
    pwm_d        = INVERT;
    ps_d         = ps;
    prev_count_d = count;
    if (ps) begin
      // A load coinciding with the boundary bypasses the shadow entirely.
      if (duty_load)   eff = duty_in;
      else if (pend_q) eff = shadow_q;
      duty_d = eff;
      pend_d = 1'b0;
    end else if (duty_load) begin
      shadow_d = duty_in;
      pend_d   = 1'b1;
    end
    if ((state_q == S_RUN) || ps)
      pwm_d = (count < eff) ^ INVERT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_count_q <= '0;
      shadow_q     <= '0;
      duty_q       <= RESET_DUTY;
      pend_q       <= 1'b0;
      pwm_q        <= INVERT;
      ps_q         <= 1'b0;
    end else begin
      prev_count_q <= prev_count_d;
      shadow_q     <= shadow_d;
      duty_q       <= duty_d;
      pend_q       <= pend_d;
      pwm_q        <= pwm_d;
      ps_q         <= ps_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign duty_active  = duty_q;
  assign load_pending = pend_q;

endmodule

// File: doc/count_pwm_gen.md
Name: count_pwm_gen

Overview:
Downstream consumer of the 8-bit free-running counter. Samples the counter's count bus and produces a PWM waveform whose duty cycle comes from a software-loaded duty value. A shadow register makes duty updates glitch-free: a new value takes effect only at a period boundary, when the count wraps to 0. The block also issues a one-cycle period_start strobe for downstream timing logic.

Parameters:
WIDTH, 8, width of count and duty buses (must match the counter width)
INVERT, 0, 1 = active-low pwm_out (output polarity inverted)
RESET_DUTY, 0, value of duty_active after reset

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
count  input  WIDTH  counter value from the upstream 8-bit counter
duty_in  input  WIDTH  requested duty value
duty_load  input  1  one-cycle strobe: capture duty_in into the shadow register
pwm_out  output  1  PWM output (registered)
period_start  output  1  one-cycle pulse at each detected period start
duty_active  output  WIDTH  duty value currently in effect
load_pending  output  1  a shadow value is waiting for the next period start

Behaviour:
- Interface: one clock (clk). reset is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values:
  - pwm_out = INVERT
  - period_start = 0
  - duty_active = RESET_DUTY
  - load_pending = 0
  - shadow = 0
  - prev_count = 0
  - FSM = IDLE
- Period start (ps) condition, evaluated combinationally each cycle:
  - count == 0 and prev_count != 0, or
  - count == 0 while FSM == IDLE.
  - prev_count <= count every cycle.
  - A count that stalls at 0 (upstream enable low) does not re-trigger ps.
- FSM:
  - IDLE: pwm_out is held at its inactive level. On ps, go to RUN.
  - RUN: generate PWM. Return to IDLE only on reset.
  - An upstream counter reset (count forced to 0 mid-period) is a legal ps while in RUN.
- Shadow register:
  - duty_load = 1 with no ps: shadow <= duty_in, load_pending <= 1. A later load before the boundary overwrites the earlier one (last write wins).
  - On ps with load_pending = 1 and no duty_load: duty_active <= shadow, load_pending <= 0.
  - duty_load and ps in the same cycle: duty_active <= duty_in directly (bypass), load_pending <= 0. Any older shadow value is discarded.
  - On ps with neither pending nor load: duty_active is unchanged.
- PWM:
  - The effective duty (eff) is the value duty_active takes in this cycle's update.
  - In RUN and on the IDLE->RUN cycle: pwm_out <= (count < eff) XOR INVERT.
  - Latency: pwm_out follows count with 1 cycle of delay.
  - duty = 0 gives pwm_out constantly inactive.
  - duty = 255 gives an active level for counts 0..254 and inactive at 255.
  - Comparison is unsigned, WIDTH bits; there is no saturation or overflow.
- period_start <= ps, registered, so it is 1 cycle after count reaches 0. It is never asserted for 2 consecutive cycles.
- Count hold (upstream enable low): pwm_out holds its value because count is unchanged. No ps occurs. A pending load stays pending.
- Reset mid-operation: every output returns to its reset value on the next edge. The pending load is lost. The FSM goes to IDLE and needs a fresh ps.

Test Plan:
- Reset then upstream count 0,1,2,...: period_start = 1 one cycle after the first count == 0. pwm_out stays at 0 while reset is high. duty_active = 0, so pwm_out stays 0 throughout.
- Wrap detection: load duty 64, then run count 0..255..0. Check:
  - duty_active = 64 one cycle after ps (count == 0), not before.
  - pwm_out = 1 for exactly 64 cycles per 256-cycle period.
  - period_start pulses once per wrap.
- Mid-period update: in RUN with duty 64, load 192 at count 100. Check:
  - load_pending = 1 until the wrap.
  - Current period keeps 64 high cycles; next period has 192.
  - Load 10 then 20 before the wrap: 20 takes effect.
- Simultaneous duty_load = 1 (duty_in = 128) and count == 0 transition: duty_active = 128 on that edge, load_pending stays 0, 128 high cycles in that period.
- Upstream enable low for 20 cycles at count 0: only one period_start, and pwm_out holds its level. Enable low at count 50 with duty 64: pwm_out holds 1 and no period_start occurs.
- Boundary duties and polarity:
  - duty 0 gives pwm_out = 0 for the full period.
  - duty 255 gives 255 high cycles plus 1 low.
  - INVERT = 1 complements pwm_out, including its reset value (1).
  - reset = 1 mid-period returns all outputs to reset values within 1 cycle, and the next pulse needs a new count == 0.
